video_raster_int: RTL and testbench
===================================

// Module: video_raster_int
// PURPOSE
//  Raster timing and Z80 interrupt generator for the video path.
//  - Runs the horizontal and vertical raster counters.
//  - Emits line_start_s and int_start to the video port latch block.
//  - Consumes that block's hint_beg and vint_beg to place the frame interrupt.
//  - Drives the Z80 /INT line with a timed assertion and an acknowledge handshake.
// PARAMETERS
//  H_TOTAL  448  ticks per line; hcount runs 0..H_TOTAL-1
//  V_TOTAL  320  lines per frame; vcount runs 0..V_TOTAL-1
//  INT_LEN  32   max /INT assertion length, in ticks
// PORTS
//  clk           in   1  system clock
//  res           in   1  reset; asynchronous, active-high
//  ce            in   1  pixel tick enable; all counting qualified by ce
//  hint_beg      in   8  INT horizontal position, in units of 2 ticks
//  vint_beg      in   9  INT line number
//  inta          in   1  Z80 interrupt acknowledge strobe, 1 clk
//  lint_en       in   1  per-line INT enable (used only with VIDEO_LINE_INT_EN)
//  hcount        out  9  horizontal tick counter
//  vcount        out  9  line counter
//  line_start_s  out  1  1-clk strobe: ce && hcount wraps to 0
//  frame_start   out  1  1-clk strobe: line_start_s && vcount wraps to 0
//  int_start     out  1  1-clk strobe at the INT match point
//  int_n         out  1  Z80 /INT, active low
// BEHAVIOUR
//  - Reset (async): hcount=0, vcount=0, strobes=0, int_n=1, FSM=IDLE, timer=0.
//  - Counters, on ce:
//    - hcount increments and wraps at H_TOTAL-1 -> 0.
//    - On that wrap, vcount increments and wraps at V_TOTAL-1 -> 0.
//    - No ce: all counters hold and all strobes are 0.
//  - Strobes are registered: asserted in the clk after the ce edge that produced
//    the new count; each lasts exactly 1 clk.
//  - Match: ce && hcount == {hint_beg,1'b0} && vcount == vint_beg.
//    - int_start asserts 1 clk later.
//    - hint_beg/vint_beg are sampled in the match cycle only. Upstream may
//      change vint_beg on the clk of int_start without re-triggering.
//  - Out-of-range:
//    - {hint_beg,0} >= H_TOTAL or vint_beg >= V_TOTAL -> never matches, no INT.
//  - INT FSM:
//    - IDLE:
//      - int_start -> ASSERT; int_n=0; timer=INT_LEN-1.
//    - ASSERT:
//      - each ce decrements timer.
//      - timer==0 && ce -> IDLE, int_n=1.
//      - inta -> IDLE, int_n=1 next clk.
//    - int_start in ASSERT -> stays ASSERT, timer reloads to INT_LEN-1.
//    - int_start and inta in the same clk -> int_start wins (ASSERT, reload).
//    - inta in IDLE -> ignored.
//  - Reset mid-assertion releases int_n immediately (async).
// CONFIGURATION
//  - VIDEO_LINE_INT_EN defined:
//    - Match ignores vcount when lint_en=1, giving one INT per line at
//      hint_beg.
//    - lint_en=0 gives frame-only behaviour.
//  - VIDEO_LINE_INT_EN undefined:
//    - lint_en is ignored; frame INT only.
//    - Per-line compare logic is not built.
// STRUCTURE
//  - Package video_timing_pkg holds:
//    - H_TOTAL/V_TOTAL defaults.
//    - The int_state_t enum {IDLE, ASSERT}.
//    - The 9-bit raster count typedef.
//  - Sub-module video_int_stretch holds the INT FSM and timer: int_start, inta,
//    ce in; int_n out. The top level keeps counters and comparators.
// TESTING
//  - Reset: assert res mid-frame, ce free-running -> hcount=vcount=0 and
//    int_n=1 in the same cycle; first line_start_s after 448 ce.
//  - Wrap: 448*320 ce -> exactly 320 line_start_s and 1 frame_start; vcount
//    never reaches 320.
//  - Frame INT: hint_beg=1, vint_beg=0 -> int_start 1 clk after hcount=2,
//    vcount=0; int_n low for 32 ce.
//  - Ack: inta 5 ce after int_n falls -> int_n=1 on the next clk; a second
//    inta in IDLE has no effect.
//  - Range: vint_beg=320 or hint_beg=224 -> no int_start over 2 frames;
//    int_start coincident with inta -> int_n stays low, timer reloaded.
//  - Line INT (macro on): lint_en=1, hint_beg=10 -> int_start on every line at
//    hcount=20. Macro off: lint_en=1 -> one INT per frame only.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: raster timing defaults and shared types for the video path
//   H_TOTAL_DEF / V_TOTAL_DEF : default ticks per line / lines per frame
//   INT_LEN_DEF               : default maximum /INT assertion length in ticks
//   raster_cnt_t              : 9-bit raster counter type
//   int_state_t               : interrupt stretcher states
package video_timing_pkg;
    localparam int H_TOTAL_DEF = 448;
    localparam int V_TOTAL_DEF = 320;
    localparam int INT_LEN_DEF = 32;
    typedef logic [8:0] raster_cnt_t;
    typedef enum logic {IDLE, ASSERT} int_state_t;
endpackage

// File: rtl/video_raster_int_if.sv
// video_raster_int_if: raster timing / interrupt bus between the raster block and its users
//   master : raster block side (takes ce, INT position, inta, lint_en; drives counts, strobes, int_n)
//   slave  : user side (video port latch block and Z80 glue)
interface video_raster_int_if;
    import video_timing_pkg::*;
    logic        ce;
    logic [7:0]  hint_beg;
    raster_cnt_t vint_beg;
    logic        inta;
    logic        lint_en;
    raster_cnt_t hcount;
    raster_cnt_t vcount;
    logic        line_start_s;
    logic        frame_start;
    logic        int_start;
    logic        int_n;
    modport master (
        input  ce, hint_beg, vint_beg, inta, lint_en,
        output hcount, vcount, line_start_s, frame_start, int_start, int_n
    );
    modport slave (
        output ce, hint_beg, vint_beg, inta, lint_en,
        input  hcount, vcount, line_start_s, frame_start, int_start, int_n
    );
endinterface

// File: rtl/video_int_stretch.sv
// video_int_stretch: Z80 /INT stretcher with acknowledge handshake
//   clk, res  : clock, asynchronous active-high reset
//   ce        : pixel tick enable; the assertion timer counts ticks
//   int_start : 1-clk request; (re)starts an assertion of INT_LEN ticks
//   inta      : 1-clk acknowledge; ends an active assertion
//   int_n     : /INT, active low, registered
module video_int_stretch
    import video_timing_pkg::*;
#(
    parameter int INT_LEN = INT_LEN_DEF
) (
    input  logic clk,
    input  logic res,
    input  logic ce,
    input  logic int_start,
    input  logic inta,
    output logic int_n
);
    localparam int TW = $clog2(INT_LEN + 1);
    int_state_t    state;
    logic [TW-1:0] timer;
    // int_start is checked first so a request coinciding with inta reloads rather than releases
    always_ff @(posedge clk or posedge res)
        if (res) begin
            state <= IDLE;
            timer <= '0;
            int_n <= 1'b1;
        end else if (int_start) begin
            state <= ASSERT;
            timer <= TW'(INT_LEN - 1);
            int_n <= 1'b0;
        end else if (state == ASSERT) begin
            if (inta || (ce && timer == '0)) begin
                state <= IDLE;
                int_n <= 1'b1;
            end else if (ce) begin
                timer <= timer - 1'b1;
            end
        end
endmodule

// File: rtl/video_raster_int.sv
// video_raster_int: raster counters, INT position match and Z80 /INT generation
//   clk, res : clock, asynchronous active-high reset
//   bus      : video_raster_int_if.master
//              in : ce, hint_beg (units of 2 ticks), vint_beg, inta, lint_en
//              out: hcount, vcount, line_start_s, frame_start, int_start, int_n
//   Build option VIDEO_LINE_INT_EN: lint_en=1 matches on every line at hint_beg.
//   Without it lint_en is ignored and only the frame interrupt exists.
module video_raster_int
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF,
    parameter int INT_LEN = INT_LEN_DEF
) (
    input logic clk,
    input logic res,
    video_raster_int_if.master bus
);
    logic h_wrap;
    logic v_wrap;
    logic v_hit;
    logic match;
`ifdef VIDEO_LINE_INT_EN
    always_comb v_hit = bus.lint_en || bus.vcount == bus.vint_beg;
`else
    logic unused_lint_en;
    assign unused_lint_en = bus.lint_en;
    always_comb v_hit = bus.vcount == bus.vint_beg;
`endif
    // out-of-range positions need no guard: the counters never reach them
    always_comb begin
        h_wrap = bus.hcount == raster_cnt_t'(H_TOTAL - 1);
        v_wrap = bus.vcount == raster_cnt_t'(V_TOTAL - 1);
        match  = bus.ce && bus.hcount == {bus.hint_beg, 1'b0} && v_hit;
    end
    always_ff @(posedge clk or posedge res)
        if (res) begin
            bus.hcount       <= '0;
            bus.vcount       <= '0;
            bus.line_start_s <= 1'b0;
            bus.frame_start  <= 1'b0;
            bus.int_start    <= 1'b0;
        end else begin
            if (bus.ce) begin
                bus.hcount <= h_wrap ? '0 : bus.hcount + 1'b1;
                if (h_wrap)
                    bus.vcount <= v_wrap ? '0 : bus.vcount + 1'b1;
            end
            bus.line_start_s <= bus.ce && h_wrap;
            bus.frame_start  <= bus.ce && h_wrap && v_wrap;
            bus.int_start    <= match;
        end
    video_int_stretch #(.INT_LEN(INT_LEN)) u_stretch (
        .clk       (clk),
        .res       (res),
        .ce        (bus.ce),
        .int_start (bus.int_start),
        .inta      (bus.inta),
        .int_n     (bus.int_n)
    );
endmodule

// File: tb/tb_video_raster_int.sv
// tb_video_raster_int: randomized and directed checks of video_raster_int against a tick-position model
module tb_video_raster_int;
    import video_timing_pkg::*;
    localparam int H = 24;
    localparam int V = 10;
    localparam int L = 32;
    localparam int F = H * V;
`ifdef VIDEO_LINE_INT_EN
    localparam bit LINE_INT = 1'b1;
`else
    localparam bit LINE_INT = 1'b0;
`endif
    logic clk = 1'b0;
    logic res = 1'b0;
    video_raster_int_if bus ();
    video_raster_int #(.H_TOTAL(H), .V_TOTAL(V), .INT_LEN(L)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.master)
    );
    always #5 clk = ~clk;
    int vectors = 0;
    int miscompares = 0;
    int pos;
    bit m_ls, m_fs, m_is, m_act;
    int m_left;
    int n_ls, n_fs, n_is, n_low;
    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        pos = 0;
        m_ls = 0;
        m_fs = 0;
        m_is = 0;
        m_act = 0;
        m_left = 0;
    endtask
    // one clock edge: position advances by one tick on ce, /INT tracks remaining ticks
    task automatic model_edge();
        int h;
        int v;
        bit hit;
        h = pos % H;
        v = pos / H;
        hit = bus.ce && h == 2 * int'(bus.hint_beg) && (v == int'(bus.vint_beg) || (LINE_INT && bus.lint_en));
        if (m_is) begin
            m_act = 1;
            m_left = L;
        end else if (m_act && bus.inta) begin
            m_act = 0;
        end else if (m_act && bus.ce) begin
            m_left--;
            if (m_left == 0) m_act = 0;
        end
        if (bus.ce) pos = (pos + 1) % F;
        m_ls = bus.ce && pos % H == 0;
        m_fs = bus.ce && pos == 0;
        m_is = hit;
    endtask
    task automatic check_all();
        check("hcount", bus.hcount, pos % H);
        check("vcount", bus.vcount, pos / H);
        check("line_start_s", bus.line_start_s, m_ls);
        check("frame_start", bus.frame_start, m_fs);
        check("int_start", bus.int_start, m_is);
        check("int_n", bus.int_n, !m_act);
        n_ls += int'(bus.line_start_s);
        n_fs += int'(bus.frame_start);
        n_is += int'(bus.int_start);
        n_low += int'(!bus.int_n);
    endtask
    task automatic clear_tally();
        n_ls = 0;
        n_fs = 0;
        n_is = 0;
        n_low = 0;
    endtask
    task automatic step(input bit c, input bit a);
        bus.ce = c;
        bus.inta = a;
        @(posedge clk);
        if (res) model_reset();
        else model_edge();
        #1 check_all();
    endtask
    task automatic set_pos(input int hb, input int vb, input bit le);
        bus.hint_beg = 8'(hb);
        bus.vint_beg = raster_cnt_t'(vb);
        bus.lint_en = le;
    endtask
    // asserts res between edges and checks the asynchronous clear before any clock
    task automatic async_reset();
        #2 res = 1'b1;
        #1;
        check("rst_hcount", bus.hcount, 0);
        check("rst_vcount", bus.vcount, 0);
        check("rst_int_n", bus.int_n, 1);
        model_reset();
        step(1, 0);
        #2 res = 1'b0;
    endtask
    task automatic wait_int_start(input string tag);
        int k;
        k = 0;
        while (!m_is && k < 2 * F) begin
            step(1, 0);
            k++;
        end
        check(tag, int'(m_is && bus.int_start), 1);
    endtask
    int range_h[5] = '{12, 224, 1, 1, 255};
    int range_v[5] = '{0, 0, 10, 320, 511};
    initial begin
        int k;
        bus.ce = 1'b0;
        bus.inta = 1'b0;
        set_pos(1, 0, 0);
        model_reset();
        clear_tally();
        #1 res = 1'b1;
        #1 check_all();
        repeat (3) step(1, 0);
        res = 1'b0;
        clear_tally();
        repeat (2 * F) step(1, 0);
        check("lines_2frames", n_ls, 2 * V);
        check("frames_2frames", n_fs, 2);
        check("ints_2frames", n_is, 2);
        check("int_low_ce", n_low, 2 * L);
        wait_int_start("reach_int");
        repeat (8) step(1, 0);
        check("low_before_reset", bus.int_n, 0);
        async_reset();
        k = 0;
        while (!bus.line_start_s && k < 100) begin
            step(1, 0);
            k++;
        end
        check("first_line_ce", k, H);
        wait_int_start("ack_start");
        step(1, 0);
        check("ack_low", bus.int_n, 0);
        repeat (5) step(1, 0);
        step(1, 1);
        check("ack_release", bus.int_n, 1);
        step(1, 1);
        check("ack_idle", bus.int_n, 1);
        wait_int_start("reload_start");
        set_pos(1, 1, 0);
        clear_tally();
        repeat (2 * H) step(1, 0);
        check("reload_ints", n_is, 1);
        check("reload_low", n_low, 2 * H);
        set_pos(1, 3, 0);
        wait_int_start("coinc_start");
        step(1, 1);
        check("start_beats_inta", bus.int_n, 0);
        repeat (3) step(1, 1);
        check("inta_after_coinc", bus.int_n, 1);
        for (int i = 0; i < 5; i++) begin
            set_pos(range_h[i], range_v[i], 0);
            step(1, 0);
            clear_tally();
            repeat (2 * F) step(1, 0);
            check("range_ints", n_is, 0);
        end
        set_pos(10, 0, 1);
        step(1, 0);
        clear_tally();
        repeat (2 * F) step(1, 0);
        check("line_ints", n_is, LINE_INT ? 2 * V : 2);
        repeat (4000) begin
            if ($urandom % 48 == 0)
                set_pos(($urandom % 16 == 0) ? int'($urandom_range(12, 255)) : int'($urandom_range(0, 11)),
                        ($urandom % 16 == 0) ? int'($urandom_range(10, 511)) : int'($urandom_range(0, 9)),
                        1'($urandom % 2));
            step(1'($urandom % 4 != 0), 1'($urandom % 12 == 0));
            if ($urandom % 800 == 0) async_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
